vram_arbiter: RTL

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter_pkg.sv | 25 ++
 rtl/vram_arbiter_rr_pick2.sv | 55 +++++
 rtl/vram_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter.
//
// Contents:
//   AW_DEF, DW_DEF - default RAM address and data widths
//   owner_e        - 2-bit slot owner encoding
//
// owner     | meaning
// ----------+------------------------------------------
// OWN_NONE  | slot unused, RAM idle (address held)
// OWN_VIDEO | video fetch, never refused
// OWN_MAIN  | main-logic client access
// OWN_PAC   | pacman-sprite client access
package vram_arbiter_pkg;

  localparam int unsigned AW_DEF = 11;
  localparam int unsigned DW_DEF = 8;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_VIDEO = 2'd1,
    OWN_MAIN  = 2'd2,
    OWN_PAC   = 2'd3
  } owner_e;

endpackage

// File: rtl/vram_arbiter_rr_pick2.sv
// Two-request round-robin picker. Holds only the last winner; when both
// requests are present the one that did not win most recently is granted.
//
// Ports:
//   clk, reset - clock, synchronous active-high reset (last winner -> b)
//   en_i       - grants allowed this cycle
//   req_a_i    - request a (main)
//   req_b_i    - request b (pac)
//   gnt_a_o    - grant a, combinational
//   gnt_b_o    - grant b, combinational
module vram_arbiter_rr_pick2
  import vram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  // 1: b won most recently, so a wins the next contention
  logic last_b_q;
  logic last_b_d;

  always_comb begin
    gnt_a_o  = 1'b0;
    gnt_b_o  = 1'b0;
    last_b_d = last_b_q;
    if (en_i) begin
      if (req_a_i && req_b_i) begin
        gnt_a_o = last_b_q;
        gnt_b_o = !last_b_q;
      end else begin
        gnt_a_o = req_a_i;
        gnt_b_o = req_b_i;
      end
    end
    if (gnt_a_o) begin
      last_b_d = 1'b0;
    end else if (gnt_b_o) begin
      last_b_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Slot-based arbiter sharing one single-port video RAM between the video
// fetch and two clients (main logic, pacman sprite). Every cycle is one slot
// with exactly one owner; the RAM returns read data one cycle later, so the
// owner is registered and the matching ack / vid_valid fires in that cycle.
//
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   hpos, display_on                   - timing from hvsync_generator
//   vid_addr / vid_rdata, vid_valid    - video fetch port
//   main_req/we/addr/wdata             - main client request (held until ack)
//   main_ack, main_rdata               - main completion pulse and read data
//   pac_req/we/addr/wdata              - pac client request (held until ack)
//   pac_ack, pac_rdata                 - pac completion pulse and read data
//   ram_addr, ram_we, ram_wdata        - RAM command
//   ram_rdata                          - RAM read data, 1-cycle latency
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter logic [1:0]  VID_SLOT = 2'd0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    hpos,
  input  logic          display_on,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_rdata,
  output logic          vid_valid,
  input  logic          main_req,
  input  logic          main_we,
  input  logic [AW-1:0] main_addr,
  input  logic [DW-1:0] main_wdata,
  output logic          main_ack,
  output logic [DW-1:0] main_rdata,
  input  logic          pac_req,
  input  logic          pac_we,
  input  logic [AW-1:0] pac_addr,
  input  logic [DW-1:0] pac_wdata,
  output logic          pac_ack,
  output logic [DW-1:0] pac_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  owner_e        owner_d, owner_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] main_rdata_q, pac_rdata_q, vid_rdata_q;

  logic slot_vid;
  logic main_elig, pac_elig;
  logic gnt_main, gnt_pac;

  // Only the slot phase of the horizontal counter matters here.
  logic unused_hpos;
  assign unused_hpos = ^hpos[9:2];

  assign slot_vid = display_on && (hpos[1:0] == VID_SLOT);

  // Acks are gated by reset so a response in flight when reset arrives is dropped.
  assign main_ack  = !reset && (owner_q == OWN_MAIN);
  assign pac_ack   = !reset && (owner_q == OWN_PAC);
  assign vid_valid = !reset && (owner_q == OWN_VIDEO);

  // A client being acked this cycle has just been served; its held req is
  // not a new request, which yields the every-other-cycle rate in blanking.
  assign main_elig = main_req && !main_ack;
  assign pac_elig  = pac_req && !pac_ack;

  vram_arbiter_rr_pick2 u_pick (
    .clk     (clk),
    .reset   (reset),
    .en_i    (!slot_vid && !reset),
    .req_a_i (main_elig),
    .req_b_i (pac_elig),
    .gnt_a_o (gnt_main),
    .gnt_b_o (gnt_pac)
  );

  always_comb begin
    owner_d = OWN_NONE;
    if (!reset) begin
      if (slot_vid) begin
        owner_d = OWN_VIDEO;
      end else if (gnt_main) begin
        owner_d = OWN_MAIN;
      end else if (gnt_pac) begin
        owner_d = OWN_PAC;
      end
    end

    // Idle slots keep the previous address so the RAM sees no spurious change.
    ram_addr  = ram_addr_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (owner_d)
      OWN_VIDEO: begin
        ram_addr = vid_addr;
      end
      OWN_MAIN: begin
        ram_addr  = main_addr;
        ram_we    = main_we;
        ram_wdata = main_wdata;
      end
      OWN_PAC: begin
        ram_addr  = pac_addr;
        ram_we    = pac_we;
        ram_wdata = pac_wdata;
      end
      default: ;
    endcase
    if (reset) begin
      ram_addr = '0;
    end
  end

  // Read data passes straight through in the ack cycle and is held afterwards.
  assign main_rdata = reset ? '0 : (main_ack  ? ram_rdata : main_rdata_q);
  assign pac_rdata  = reset ? '0 : (pac_ack   ? ram_rdata : pac_rdata_q);
  assign vid_rdata  = reset ? '0 : (vid_valid ? ram_rdata : vid_rdata_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q      <= OWN_NONE;
      ram_addr_q   <= '0;
      main_rdata_q <= '0;
      pac_rdata_q  <= '0;
      vid_rdata_q  <= '0;
    end else begin
      owner_q      <= owner_d;
      ram_addr_q   <= ram_addr;
      main_rdata_q <= main_rdata;
      pac_rdata_q  <= pac_rdata;
      vid_rdata_q  <= vid_rdata;
    end
  end

endmodule
